membus_ctrl: RTL and testbench
==============================

// Module: membus_ctrl
//
// PURPOSE
//  Memory bus cycle sequencer: the stage directly downstream of the external bus arbiter.
//  Turns the arbiter strobes (astb/rd/wr) into timed external memory cycles:
//  chip select, output/write enable, minimum wait states, ready handshake and timeout.
//  Returns read data plus a one-cycle acknowledge to the busio side.
//
// PARAMETERS
//  AW           20   memory address width
//  DW           64   data word width
//  WAIT_CYCLES  2    minimum cycles oe/we held before ready is sampled (>=1)
//  TIMEOUT      255  extra cycles to wait for i_mem_ready before error (>=1)
//
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  i_astb       in   1   address strobe from arbiter; i_addr valid this cycle
//  i_rd         in   1   read request from arbiter
//  i_wr         in   1   write request from arbiter; i_wdata valid this cycle
//  i_addr       in   AW  address
//  i_wdata      in   DW  write data
//  o_rdata      out  DW  read data, valid while o_ack=1 and held until next read
//  o_ack        out  1   one-cycle completion pulse (read or write)
//  o_err        out  1   one-cycle error pulse (protocol error or timeout)
//  o_busy       out  1   1 whenever state != IDLE
//  o_mem_addr   out  AW  latched memory address
//  o_mem_wdata  out  DW  latched write data
//  o_mem_cs     out  1   chip select
//  o_mem_oe     out  1   output enable (read)
//  o_mem_we     out  1   write enable
//  i_mem_rdata  in   DW  memory read data
//  i_mem_ready  in   1   memory ready; sampled only once the wait count is exhausted
//
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0, incl. o_rdata, o_mem_addr, o_mem_wdata.
//  All outputs registered; FSM states:
//   IDLE   : cs=0. i_astb -> latch i_addr into o_mem_addr, go ADDR. i_rd/i_wr without astb ignored.
//   ADDR   : cs=1. Exactly one of i_rd/i_wr -> go ACCESS, wait counter := WAIT_CYCLES-1.
//            i_wr also latches i_wdata into o_mem_wdata.
//            i_rd&i_wr together -> o_err pulse, go IDLE, no access.
//            i_astb again (no rd/wr) -> relatch address, stay.
//   ACCESS : cs=1, oe=1 (read) or we=1 (write).
//            Wait counter decrements to 0. At 0: i_mem_ready=1 -> capture i_mem_rdata (read only),
//            go DONE; otherwise timeout counter counts up. TIMEOUT cycles with ready low ->
//            o_err pulse, go IDLE, o_rdata unchanged.
//   DONE   : cs/oe/we=0, o_ack=1 for exactly one cycle, go IDLE.
//  Latency: rd/wr sampled at edge E -> ACCESS lasts >= WAIT_CYCLES cycles;
//   with ready high, o_ack is high in the cycle after edge E+WAIT_CYCLES.
//  i_astb/i_rd/i_wr while in ACCESS or DONE: ignored; the cycle in flight is unaffected.
//  oe and we never both 1; cs is 1 in every cycle that oe or we is 1.
//  o_ack and o_err are never both 1.
//  Counters: wait = $clog2(WAIT_CYCLES+1) bits; timeout = $clog2(TIMEOUT+1) bits; no wrap.
//  Timeout counter cleared on every entry to ACCESS.
//
// STRUCTURE
//  Package membus_pkg:
//   - typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} membus_state_t
//   - typedef enum logic {OP_READ, OP_WRITE} membus_op_t
//  Sub-module membus_timer: loadable wait down-counter plus timeout up-counter;
//   outputs wait_done and timed_out.
//  FSM, address/data latches and output registers stay in membus_ctrl.
//
// TESTING (WAIT_CYCLES=2, TIMEOUT=4 unless noted)
//  1 Read, ready high: astb addr=20'h01234 @E0, rd @E1, mem data 64'hDEAD_BEEF_0000_0001
//    -> cs high after E0; oe high 2 cycles; o_ack + o_rdata=64'hDEAD_BEEF_0000_0001 after E3.
//  2 Write, ready high: astb addr=20'h00010, wr wdata=64'h5 @E1
//    -> o_mem_wdata=5, we high 2 cycles, oe stays 0, o_ack after E3, o_rdata unchanged.
//  3 Read, ready low 3 cycles after wait expiry
//    -> ACCESS stretched 3 cycles, o_ack once, no o_err.
//  4 Read, ready stuck low
//    -> o_err pulse after 2+4 ACCESS cycles, o_ack never, FSM back to IDLE, o_busy=0.
//  5 rd&wr together in ADDR -> o_err pulse, oe/we never asserted.
//    Separately, astb during ACCESS -> ignored, o_mem_addr unchanged.
//  6 reset=0 asserted mid-ACCESS (asynchronous, between edges)
//    -> cs/oe/we/o_busy drop immediately. After release, a normal read completes as in 1.

Source files
------------

// File: rtl/membus_pkg.sv
// Shared types and defaults for the memory bus cycle sequencer.
// The enums name the sequencer states and the access direction latched in ADDR.
package membus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } membus_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } membus_op_t;

    localparam int unsigned DEF_AW          = 20;
    localparam int unsigned DEF_DW          = 64;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned DEF_TIMEOUT     = 255;

    // A legal request in ADDR names exactly one direction.
    function automatic logic single_req(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/membus_if.sv
// Arbiter-side strobes plus external memory pins of the bus sequencer.
// slave is the sequencer's view; master is the arbiter/memory side driving it.
interface membus_if
    import membus_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) ();

    logic          i_astb;
    logic          i_rd;
    logic          i_wr;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] o_rdata;
    logic          o_ack;
    logic          o_err;
    logic          o_busy;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          o_mem_cs;
    logic          o_mem_oe;
    logic          o_mem_we;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ready;

    modport slave (
        input  i_astb, i_rd, i_wr, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
        output o_rdata, o_ack, o_err, o_busy,
        output o_mem_addr, o_mem_wdata, o_mem_cs, o_mem_oe, o_mem_we
    );

    modport master (
        output i_astb, i_rd, i_wr, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
        input  o_rdata, o_ack, o_err, o_busy,
        input  o_mem_addr, o_mem_wdata, o_mem_cs, o_mem_oe, o_mem_we
    );

endinterface

// File: rtl/membus_timer.sv
// Wait-state down-counter and ready-timeout up-counter for one memory access.
// load restarts both; tick advances them while the access is in flight.
module membus_timer
    import membus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic wait_done,
    output logic timed_out
);

    localparam int unsigned WW = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wait_cnt_r;
    logic [TW-1:0] to_cnt_r;

    // Wait count runs down first; only then does the timeout count run up, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= '0;
            to_cnt_r   <= '0;
        end else if (load) begin
            wait_cnt_r <= WW'(WAIT_CYCLES - 1);
            to_cnt_r   <= '0;
        end else if (tick) begin
            if (wait_cnt_r != '0) begin
                wait_cnt_r <= wait_cnt_r - WW'(1);
            end else if (to_cnt_r != TW'(TIMEOUT)) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
        end else begin
            wait_cnt_r <= wait_cnt_r;
            to_cnt_r   <= to_cnt_r;
        end
    end

    assign wait_done = (wait_cnt_r == '0);
    assign timed_out = (to_cnt_r == TW'(TIMEOUT));

endmodule

// File: rtl/membus_ctrl.sv
// Memory bus cycle sequencer: turns arbiter strobes into timed chip-select /
// output-enable / write-enable cycles with wait states, ready handshake and timeout.
module membus_ctrl
    import membus_pkg::*;
#(
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic     clk,
    input  logic     reset,
    membus_if.slave  bus
);

    membus_state_t state_r;
    membus_op_t    op_r;
    logic [DW-1:0] rdata_r;
    logic          ack_r;
    logic          err_r;
    logic          busy_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          cs_r;
    logic          oe_r;
    logic          we_r;

    logic          load_s;
    logic          tick_s;
    logic          wait_done_s;
    logic          timed_out_s;

    // Timer restarts on the ADDR->ACCESS hand-off and runs for the whole access.
    always_comb begin
        load_s = 1'b0;
        tick_s = 1'b0;
        if ((state_r == ADDR) && single_req(bus.i_rd, bus.i_wr)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (state_r == ACCESS) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    membus_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .tick      (tick_s),
        .wait_done (wait_done_s),
        .timed_out (timed_out_s)
    );

    // Sequencer FSM with registered memory pins, latches and one-cycle ack/err pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            op_r        <= OP_READ;
            rdata_r     <= '0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            cs_r        <= 1'b0;
            oe_r        <= 1'b0;
            we_r        <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.i_astb) begin
                        mem_addr_r <= bus.i_addr;
                        cs_r       <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ADDR;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ADDR: begin
                    if (bus.i_rd && bus.i_wr) begin
                        err_r   <= 1'b1;
                        cs_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (bus.i_rd) begin
                        op_r    <= OP_READ;
                        oe_r    <= 1'b1;
                        state_r <= ACCESS;
                    end else if (bus.i_wr) begin
                        op_r        <= OP_WRITE;
                        we_r        <= 1'b1;
                        mem_wdata_r <= bus.i_wdata;
                        state_r     <= ACCESS;
                    end else if (bus.i_astb) begin
                        mem_addr_r <= bus.i_addr;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                ACCESS: begin
                    // Ready is only looked at once the minimum wait has elapsed.
                    if (wait_done_s && bus.i_mem_ready) begin
                        if (op_r == OP_READ) begin
                            rdata_r <= bus.i_mem_rdata;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        ack_r   <= 1'b1;
                        cs_r    <= 1'b0;
                        oe_r    <= 1'b0;
                        we_r    <= 1'b0;
                        state_r <= DONE;
                    end else if (wait_done_s && timed_out_s) begin
                        err_r   <= 1'b1;
                        cs_r    <= 1'b0;
                        oe_r    <= 1'b0;
                        we_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cs_r    <= 1'b0;
                    oe_r    <= 1'b0;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_rdata     = rdata_r;
    assign bus.o_ack       = ack_r;
    assign bus.o_err       = err_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_mem_addr  = mem_addr_r;
    assign bus.o_mem_wdata = mem_wdata_r;
    assign bus.o_mem_cs    = cs_r;
    assign bus.o_mem_oe    = oe_r;
    assign bus.o_mem_we    = we_r;

endmodule

// File: tb/tb_membus_ctrl.sv
// Directed bench for membus_ctrl: a scoreboard queue of expected ack/err responses
// checked by a monitor, plus per-transaction latency and enable-width checks.
module tb_membus_ctrl;
    import membus_pkg::*;

    localparam int AW    = 20;
    localparam int DW    = 64;
    localparam int WAITC = 2;
    localparam int TMO   = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    membus_if #(.AW(AW), .DW(DW)) bus ();

    membus_ctrl #(
        .AW          (AW),
        .DW          (DW),
        .WAIT_CYCLES (WAITC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit            is_err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_rdata;
    int            oe_cnt = 0;
    int            we_cnt = 0;
    int            acc_run = 0;
    int            ready_after = 99;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Memory model: ready rises after ready_after consecutive enable cycles.
    always @(negedge clk) begin
        if (bus.o_mem_oe) oe_cnt++;
        if (bus.o_mem_we) we_cnt++;
        if (bus.o_mem_oe || bus.o_mem_we) acc_run++;
        else acc_run = 0;
        bus.i_mem_ready = (acc_run != 0) && (acc_run >= ready_after);
    end

    // Monitor: pin invariants every cycle; responses popped from the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            n_cmp++;
            if ((bus.o_ack && bus.o_err) || (bus.o_mem_oe && bus.o_mem_we) ||
                ((bus.o_mem_oe || bus.o_mem_we) && !bus.o_mem_cs)) begin
                n_bad++;
                $display("FAIL invariant: ack=%b err=%b cs=%b oe=%b we=%b",
                         bus.o_ack, bus.o_err, bus.o_mem_cs, bus.o_mem_oe, bus.o_mem_we);
            end
            if (bus.o_ack || bus.o_err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got ack=%b err=%b, expected none", bus.o_ack, bus.o_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_err", 64'(bus.o_err), 64'(mon_e.is_err));
                    check("resp_rdata", bus.o_rdata, mon_e.rdata);
                end
            end
        end
    end

    task automatic run_txn(input string nm, input logic [AW-1:0] addr, input bit do_rd,
                           input bit do_wr, input logic [DW-1:0] wd, input logic [DW-1:0] md,
                           input int low_n, input bit astb_mid, input bit exp_err,
                           input int exp_lat, input int exp_oe, input int exp_we);
        int   lat;
        int   oe0;
        int   we0;
        exp_t e;
        ready_after     = WAITC + low_n;
        bus.i_mem_rdata = md;
        @(negedge clk);
        bus.i_astb = 1'b1;
        bus.i_addr = addr;
        @(negedge clk);
        check({nm, "/cs_after_astb"}, 64'(bus.o_mem_cs), 64'd1);
        check({nm, "/addr_latched"}, 64'(bus.o_mem_addr), 64'(addr));
        check({nm, "/busy"}, 64'(bus.o_busy), 64'd1);
        bus.i_astb  = 1'b0;
        bus.i_rd    = do_rd;
        bus.i_wr    = do_wr;
        bus.i_wdata = wd;
        oe0 = oe_cnt;
        we0 = we_cnt;
        if (do_rd && !do_wr && !exp_err) model_rdata = md;
        e.is_err = exp_err;
        e.rdata  = model_rdata;
        exp_q.push_back(e);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            bus.i_rd = 1'b0;
            bus.i_wr = 1'b0;
            if (astb_mid) begin
                bus.i_astb = (lat == 1);
                bus.i_addr = ~addr;
            end
            if (bus.o_ack || bus.o_err) break;
        end
        bus.i_astb = 1'b0;
        check({nm, "/latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "/oe_cycles"}, 64'(oe_cnt - oe0), 64'(exp_oe));
        check({nm, "/we_cycles"}, 64'(we_cnt - we0), 64'(exp_we));
        check({nm, "/mem_addr_held"}, 64'(bus.o_mem_addr), 64'(addr));
        if (do_wr && !do_rd) check({nm, "/mem_wdata"}, bus.o_mem_wdata, wd);
        @(negedge clk);
        check({nm, "/idle_busy"}, 64'(bus.o_busy), 64'd0);
        check({nm, "/idle_cs"}, 64'(bus.o_mem_cs), 64'd0);
    endtask

    initial begin
        bus.i_astb      = 1'b0;
        bus.i_rd        = 1'b0;
        bus.i_wr        = 1'b0;
        bus.i_addr      = '0;
        bus.i_wdata     = '0;
        bus.i_mem_rdata = '0;
        model_rdata     = '0;
        reset           = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {58'd0, bus.o_ack, bus.o_err, bus.o_busy, bus.o_mem_cs,
                            bus.o_mem_oe, bus.o_mem_we}, 64'd0);
        check("reset_rdata", bus.o_rdata, 64'd0);
        check("reset_addr", 64'(bus.o_mem_addr), 64'd0);
        check("reset_wdata", bus.o_mem_wdata, 64'd0);
        reset = 1'b1;

        // Latency = WAIT + ready-low cycles + 1; timeout err after WAIT+TIMEOUT+1.
        run_txn("rd_ready", 20'h01234, 1'b1, 1'b0, 64'd0, 64'hDEAD_BEEF_0000_0001,
                0, 1'b0, 1'b0, 3, 2, 0);
        run_txn("wr_ready", 20'h00010, 1'b0, 1'b1, 64'd5, 64'hAAAA_AAAA_AAAA_AAAA,
                0, 1'b0, 1'b0, 3, 0, 2);
        run_txn("rd_stretch", 20'h00ABC, 1'b1, 1'b0, 64'd0, 64'h1111_2222_3333_4444,
                3, 1'b1, 1'b0, 6, 5, 0);
        run_txn("rd_timeout", 20'h00200, 1'b1, 1'b0, 64'd0, 64'h5555_6666_7777_8888,
                99, 1'b0, 1'b1, 7, 6, 0);
        run_txn("rd_wr_both", 20'h00333, 1'b1, 1'b1, 64'd9, 64'h9999_0000_9999_0000,
                0, 1'b0, 1'b1, 1, 0, 0);

        // Asynchronous reset in the middle of an access.
        ready_after     = 99;
        bus.i_mem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        bus.i_astb = 1'b1;
        bus.i_addr = 20'h00300;
        @(negedge clk);
        bus.i_astb = 1'b0;
        bus.i_rd   = 1'b1;
        @(negedge clk);
        bus.i_rd = 1'b0;
        check("midreset/oe_before", 64'(bus.o_mem_oe), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midreset/pins", {60'd0, bus.o_mem_cs, bus.o_mem_oe, bus.o_mem_we, bus.o_busy}, 64'd0);
        check("midreset/rdata", bus.o_rdata, 64'd0);
        model_rdata = '0;
        @(negedge clk);
        reset = 1'b1;

        run_txn("rd_after_reset", 20'h01234, 1'b1, 1'b0, 64'd0, 64'hDEAD_BEEF_0000_0001,
                0, 1'b0, 1'b0, 3, 2, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
